// File: rtl/ln_sched.sv
// Round-robin scheduler sharing one ln lookup table among N_REQ requesters.
// Arguments above the table range are halved; each halving adds ln(2) to the result.
module ln_sched #(
    parameter int unsigned N_REQ   = 4,
    parameter int          LUT_MAX = 101,
    parameter logic [31:0] LN2     = 32'h0000B172
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ*32-1:0]  req_x,
    output logic [N_REQ-1:0]     req_ready,
    output logic [31:0]          lut_x,
    input  logic [31:0]          lut_y,
    output logic                 resp_valid,
    output logic [2:0]           resp_id,
    output logic [31:0]          resp_y,
    output logic                 resp_err,
    input  logic                 resp_ready
);

    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int          NR = int'(N_REQ);

    typedef enum logic [1:0] {StIdle, StReduce, StLookup, StResp} state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic signed [31:0] x_q, x_d;
    logic [4:0]         k_q, k_d;
    logic [31:0]        y_q, y_d;
    logic [2:0]         id_q, id_d;
    logic               err_q, err_d;

    logic [N_REQ-1:0]   grant;
    logic [PW-1:0]      gnt_idx;
    logic signed [31:0] gnt_x;
    logic               found;

    // Two passes: requesters at/after rr_ptr first, then the wrapped-around ones.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        gnt_x   = '0;
        found   = 1'b0;
        if (state_q == StIdle && !rst) begin
            for (int i = 0; i < NR; i++) begin
                if (!found && req_valid[i] && i >= int'(rr_ptr_q)) begin
                    found    = 1'b1;
                    grant[i] = 1'b1;
                    gnt_idx  = PW'(i);
                    gnt_x    = req_x[i*32 +: 32];
                end
            end
            for (int i = 0; i < NR; i++) begin
                if (!found && req_valid[i] && i < int'(rr_ptr_q)) begin
                    found    = 1'b1;
                    grant[i] = 1'b1;
                    gnt_idx  = PW'(i);
                    gnt_x    = req_x[i*32 +: 32];
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        x_d      = x_q;
        k_d      = k_q;
        y_d      = y_q;
        id_d     = id_q;
        err_d    = err_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    x_d      = gnt_x;
                    id_d     = 3'(gnt_idx);
                    k_d      = '0;
                    rr_ptr_d = (gnt_idx == PW'(NR - 1)) ? '0 : gnt_idx + 1'b1;
                    err_d    = 1'b0;
                    if (gnt_x <= 0) begin
                        err_d   = 1'b1;
                        y_d     = '0;
                        state_d = StResp;
                    end else if (gnt_x > LUT_MAX) begin
                        state_d = StReduce;
                    end else begin
                        state_d = StLookup;
                    end
                end
            end
            StReduce: begin
                // x is known positive here, so the arithmetic shift is a plain halving.
                x_d = x_q >>> 1;
                k_d = k_q + 5'd1;
                if (x_d <= LUT_MAX) begin
                    state_d = StLookup;
                end
            end
            StLookup: begin
                y_d     = lut_y + {27'd0, k_q} * LN2;
                state_d = StResp;
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            x_q      <= '0;
            k_q      <= '0;
            y_q      <= '0;
            id_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            x_q      <= x_d;
            k_q      <= k_d;
            y_q      <= y_d;
            id_q     <= id_d;
            err_q    <= err_d;
        end
    end

    assign req_ready  = grant;
    assign lut_x      = (state_q == StLookup) ? x_q : 32'd0;
    assign resp_valid = (state_q == StResp);
    assign resp_id    = id_q;
    assign resp_y     = y_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_ln_sched.sv
// Self-checking bench for ln_sched: vector table plus scoreboard, hold, reset and
// round-robin sequences against a small ln table model.
module tb_ln_sched;

    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [N*32-1:0]  req_x = '0;
    logic [N-1:0]     req_ready;
    logic [31:0]      lut_x;
    logic [31:0]      lut_y;
    logic             resp_valid;
    logic [2:0]       resp_id;
    logic [31:0]      resp_y;
    logic             resp_err;
    logic             resp_ready = 1'b1;

    ln_sched #(.N_REQ(N), .LUT_MAX(101), .LN2(32'h0000B172)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_x      (req_x),
        .req_ready  (req_ready),
        .lut_x      (lut_x),
        .lut_y      (lut_y),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_y     (resp_y),
        .resp_err   (resp_err),
        .resp_ready (resp_ready)
    );

    always #5 clk = ~clk;

    // Table model: truncated 16.16 ln for the spec points, a synthetic ramp elsewhere.
    function automatic logic [31:0] lut_fn(input logic [31:0] a);
        if (a == 32'd2)   return 32'h0000B172;
        if (a == 32'd101) return 32'd302456;
        return a * 32'd256 + 32'd7;
    endfunction

    assign lut_y = lut_fn(lut_x);

    typedef struct {
        logic [2:0]  id;
        logic [31:0] y;
        logic        err;
        int          lat;
    } exp_t;

    typedef struct {
        int          id;
        logic [31:0] x;
        logic [31:0] y;
        logic        err;
        int          lat;
        logic [31:0] lut;
    } vec_t;

    exp_t        sb[$];
    exp_t        e;
    vec_t        vecs[9];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          acc_count = 0;
    int          last_acc_cyc = 0;
    int          first_cyc = 0;
    int          resp_count = 0;
    logic        prev_rv = 1'b0;
    logic [31:0] last_lut = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: sample at the falling edge, track accepts and score responses.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (lut_x != 32'd0) last_lut = lut_x;
            if (|(req_valid & req_ready)) begin
                acc_count++;
                last_acc_cyc = cyc;
            end
            if (resp_valid && !prev_rv) first_cyc = cyc;
            if (resp_valid && resp_ready) begin
                resp_count++;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_resp: got id %0d y %h, expected no response",
                             resp_id, resp_y);
                end else begin
                    e = sb.pop_front();
                    check("resp_id", {29'd0, resp_id}, {29'd0, e.id});
                    check("resp_y", resp_y, e.y);
                    check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                    check("latency", 32'(first_cyc - last_acc_cyc), 32'(e.lat));
                end
            end
            prev_rv = resp_valid;
        end else begin
            prev_rv = 1'b0;
        end
    end

    task automatic wait_accept(input int prev);
        int n = 0;
        while (acc_count == prev && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("accept_timeout", 32'(acc_count == prev), 32'd0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int prev;
        int snap;
        int rcount;
        int n;

        vecs[0] = '{0, 32'd2,          32'h0000B172, 1'b0, 2,  32'd2};
        vecs[1] = '{1, 32'd404,        32'h0006005C, 1'b0, 4,  32'd101};
        vecs[2] = '{2, 32'd0,          32'd0,        1'b1, 1,  32'd0};
        vecs[3] = '{2, 32'hFFFFFFFB,   32'd0,        1'b1, 1,  32'd0};
        vecs[4] = '{3, 32'd101,        32'd302456,   1'b0, 2,  32'd101};
        vecs[5] = '{0, 32'd1,          32'h00000107, 1'b0, 2,  32'd1};
        vecs[6] = '{1, 32'd102,        32'h0000E479, 1'b0, 3,  32'd51};
        vecs[7] = '{3, 32'h7FFFFFFF,   32'h00119329, 1'b0, 27, 32'd63};
        vecs[8] = '{0, 32'h80000000,   32'd0,        1'b1, 1,  32'd0};

        // Reset state, with every requester asking during reset.
        req_valid = '1;
        for (int i = 0; i < N; i++) req_x[i*32 +: 32] = 32'(i + 3);
        repeat (2) @(negedge clk);
        check("rst_req_ready", {28'd0, req_ready}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_id", {29'd0, resp_id}, 32'd0);
        check("rst_resp_y", resp_y, 32'd0);
        check("rst_resp_err", {31'd0, resp_err}, 32'd0);
        check("rst_lut_x", lut_x, 32'd0);
        req_valid = '0;
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
            last_lut = '0;
            sb.push_back('{3'(vecs[i].id), vecs[i].y, vecs[i].err, vecs[i].lat});
            prev = acc_count;
            req_x[vecs[i].id*32 +: 32] = vecs[i].x;
            req_valid[vecs[i].id] = 1'b1;
            wait_accept(prev);
            req_valid[vecs[i].id] = 1'b0;
            wait_drain();
            check("lut_x_arg", last_lut, vecs[i].lut);
        end

        // Consumer stalls: response must hold and nobody else may be granted.
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        sb.push_back('{3'd1, 32'd1287, 1'b0, 2});
        sb.push_back('{3'd2, 32'd1799, 1'b0, 2});
        prev = acc_count;
        req_x[1*32 +: 32] = 32'd5;
        req_x[2*32 +: 32] = 32'd7;
        req_valid[1] = 1'b1;
        req_valid[2] = 1'b1;
        wait_accept(prev);
        req_valid[1] = 1'b0;
        n = 0;
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("hold_resp_timeout", {31'd0, resp_valid}, 32'd1);
        snap = acc_count;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("hold_valid", {31'd0, resp_valid}, 32'd1);
            check("hold_id", {29'd0, resp_id}, 32'd1);
            check("hold_y", resp_y, 32'd1287);
            check("hold_err", {31'd0, resp_err}, 32'd0);
            check("hold_req_ready", {28'd0, req_ready}, 32'd0);
        end
        check("hold_no_accept", 32'(acc_count), 32'(snap));
        @(posedge clk);
        #1 resp_ready = 1'b1;
        wait_accept(snap);
        req_valid[2] = 1'b0;
        wait_drain();

        // Reset mid-reduction abandons the request.
        @(posedge clk);
        #1;
        prev = acc_count;
        req_x[3*32 +: 32] = 32'h7FFFFFFF;
        req_valid[3] = 1'b1;
        wait_accept(prev);
        req_valid = '1;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("arst_resp_id", {29'd0, resp_id}, 32'd0);
        check("arst_resp_y", resp_y, 32'd0);
        check("arst_resp_err", {31'd0, resp_err}, 32'd0);
        check("arst_lut_x", lut_x, 32'd0);
        check("arst_req_ready", {28'd0, req_ready}, 32'd0);
        rcount = resp_count;
        @(posedge clk);
        #1 req_valid = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (40) @(negedge clk);
        check("arst_no_resp", 32'(resp_count), 32'(rcount));

        // All requesters busy: grants rotate 0,1,2,3,0 from a fresh pointer.
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) req_x[i*32 +: 32] = 32'(10 * (i + 1));
        for (int j = 0; j < 5; j++) begin
            sb.push_back('{3'(j % N), 32'((10 * (j % N + 1)) * 256 + 7), 1'b0, 2});
        end
        prev = acc_count;
        req_valid = '1;
        n = 0;
        while (acc_count < prev + 5 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        req_valid = '0;
        check("rr_accepts", 32'(acc_count - prev), 32'd5);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ln_sched.md
LN_SCHED -- requirements
Module: ln_sched

Interface
REQ-001 SHALL have parameter N_REQ, default 4, giving the number of requesters sharing the ln lookup table (2..8).
REQ-002 SHALL have parameter LUT_MAX, default 101, giving the largest argument the table covers.
REQ-003 SHALL have parameter LN2, default 32'h0000B172, giving ln(2) in unsigned 16.16 fixed point.
REQ-004 Clk  input  1  system clock; all state updates on its rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  N_REQ  per-requester request strobe.
REQ-007 req_x  input  N_REQ*32  per-requester signed int argument; requester i occupies bits [32i+31:32i].
REQ-008 req_ready  output  N_REQ  one-hot grant, combinational from state and pointer.
REQ-009 lut_x  output  32  argument driven to the shared ln table.
REQ-010 lut_y  input  32  16.16 result from the table, combinational from lut_x.
REQ-011 resp_valid  output  1  result available.
REQ-012 resp_id  output  3  index of the requester that owns the result.
REQ-013 resp_y  output  32  16.16 natural log result.
REQ-014 resp_err  output  1  argument was <= 0; resp_y is then 0.
REQ-015 resp_ready  input  1  consumer accepts the result.

Function
REQ-016 SHALL implement FSM states IDLE, REDUCE, LOOKUP and RESP.
REQ-017 In IDLE, req_ready SHALL be one-hot on the first valid requester at or after rr_ptr, searching cyclically; otherwise all zero.
REQ-018 In REDUCE, LOOKUP and RESP, req_ready SHALL be all zero.
REQ-019 Accept occurs when req_valid[i] and req_ready[i] are both high.
REQ-020 On accept, SHALL latch x, id and k = 0, and set rr_ptr = (i+1) mod N_REQ.
REQ-021 IDLE -> RESP SHALL occur on accept with x <= 0, setting err = 1 and y = 0.
REQ-022 IDLE -> REDUCE SHALL occur on accept with x > LUT_MAX.
REQ-023 IDLE -> LOOKUP SHALL occur on accept with 1 <= x <= LUT_MAX.
REQ-024 In REDUCE, each cycle SHALL do x <= x >> 1 and k <= k + 1.
REQ-025 REDUCE SHALL move to LOOKUP in the cycle after the latched x becomes <= LUT_MAX.
REQ-026 In LOOKUP, lut_x SHALL equal the latched x, and y SHALL be latched as lut_y + k*LN2, width 32, with no overflow possible since k <= 25.
REQ-027 LOOKUP -> RESP SHALL be unconditional after one cycle.
REQ-028 Outside LOOKUP, lut_x SHALL be 0.
REQ-029 In RESP, resp_valid SHALL be 1, and resp_id, resp_y and resp_err SHALL be held stable until resp_ready is 1.
REQ-030 RESP -> IDLE SHALL occur on the resp_ready edge; a new accept is possible in the following cycle.
REQ-031 resp_valid SHALL be 0 in every state other than RESP.
REQ-032 Latency from accept to resp_valid SHALL be 2 + (number of right shifts) cycles, or 1 cycle for an error request.
REQ-033 A requester that drops req_valid before being granted SHALL lose nothing; the block has no queueing.
REQ-034 Requests arriving while busy SHALL wait; arbitration SHALL be re-evaluated only in IDLE.
REQ-035 rr_ptr SHALL wrap from N_REQ-1 to 0.

Reset
REQ-036 Reset SHALL force state IDLE, rr_ptr = 0, x = 0, k = 0, y = 0, id = 0 and err = 0 immediately.
REQ-037 During Reset, outputs SHALL be resp_valid = 0, resp_id = 0, resp_y = 0, resp_err = 0, lut_x = 0 and req_ready = 0.
REQ-038 Reset asserted mid-operation SHALL abandon the current request without producing a response.

Verification
REQ-039 Requester 0 sends x = 2 with a table model attached -> resp_valid 2 cycles after accept, resp_y = 32'h0000B172, resp_id = 0, resp_err = 0.
REQ-040 Requester 1 sends x = 404 -> 2 reduce cycles, lut_x = 101, resp_y = 32'h0006005C, response 4 cycles after accept.
REQ-041 Requester 2 sends x = 0, then x = -5 -> each gives resp_err = 1 and resp_y = 0, one cycle after accept.
REQ-042 All 4 requesters hold req_valid continuously with resp_ready = 1 -> grant order 0, 1, 2, 3, 0, and no requester is starved.
REQ-043 resp_ready is held 0 for 10 cycles -> resp_* stays stable, req_ready stays 0, and no second accept occurs.
REQ-044 Reset is pulsed during REDUCE for x = 2^31-1 -> outputs clear asynchronously and no resp_valid follows; after release, a grant starts again from requester 0.
